// File: rtl/sprite_line_scanner.sv
// Per-scanline sprite evaluator: scans OAM and builds a list of visible sprites, published atomically.
// Optional SPRITE_OVERFLOW_EN: keep scanning when full and report further hits on o_overflow.
module sprite_line_scanner #(
    parameter int MAX_PER_LINE = 32,
    parameter int OAM_DEPTH    = 64,
    parameter int OAM_ADDR_W   = 6,
    parameter int SPRITE_H     = 16,
    parameter int ROW_W        = 4,
    parameter int COORD_W      = 10,
    localparam int CNT_W       = $clog2(MAX_PER_LINE + 1)
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic                               i_start,
    input  logic [COORD_W-1:0]                 i_line,
    output logic [OAM_ADDR_W-1:0]              o_oam_addr,
    input  logic [31:0]                        i_oam_data,
    output logic [MAX_PER_LINE*OAM_ADDR_W-1:0] o_entry_idx,
    output logic [MAX_PER_LINE*ROW_W-1:0]      o_entry_row,
    output logic [MAX_PER_LINE-1:0]            o_entry_valid,
    output logic [CNT_W-1:0]                   o_entry_count,
    output logic                               o_busy,
    output logic                               o_done,
    output logic                               o_overflow
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN    = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_PUBLISH = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]      MAX_C     = CNT_W'(MAX_PER_LINE);
    localparam logic [OAM_ADDR_W-1:0] LAST_ADDR = OAM_ADDR_W'(OAM_DEPTH - 1);
    localparam logic [COORD_W:0]      HEIGHT_C  = (COORD_W + 1)'(SPRITE_H);
    localparam logic [ROW_W-1:0]      ROW_MAX   = ROW_W'(SPRITE_H - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [COORD_W-1:0]      r_line;
    logic [OAM_ADDR_W-1:0]   r_addr;
    logic                    r_eval_valid;
    logic [OAM_ADDR_W-1:0]   r_eval_idx;
    logic [CNT_W-1:0]        r_count;
    logic [OAM_ADDR_W-1:0]   r_wb_idx [MAX_PER_LINE];
    logic [ROW_W-1:0]        r_wb_row [MAX_PER_LINE];
    logic                    r_ovf;

    logic [MAX_PER_LINE*OAM_ADDR_W-1:0] r_pub_idx;
    logic [MAX_PER_LINE*ROW_W-1:0]      r_pub_row;
    logic [MAX_PER_LINE-1:0]            r_pub_valid;
    logic [CNT_W-1:0]                   r_pub_count;
    logic                               r_pub_ovf;
    logic                               r_done;
    logic                               r_busy;

    logic [COORD_W-1:0]      w_ypos;
    logic [COORD_W:0]        w_diff;
    logic                    w_hit;
    logic [ROW_W-1:0]        w_row;
    logic                    w_wr;
    logic                    w_ovf_hit;
    logic [CNT_W-1:0]        w_count_nxt;
    logic                    w_early_full;
    logic                    w_pub;
    logic                    w_unused;

    // Hit test on the word returned for r_eval_idx; the unsigned borrow bit rejects ypos > line.
    always_comb begin
        w_ypos      = COORD_W'(i_oam_data[27:18]);
        w_diff      = {1'b0, r_line} - {1'b0, w_ypos};
        w_hit       = r_eval_valid && i_oam_data[31] && !w_diff[COORD_W] && (w_diff < HEIGHT_C);
        w_row       = i_oam_data[30] ? (ROW_MAX - w_diff[ROW_W-1:0]) : w_diff[ROW_W-1:0];
        w_wr        = w_hit && (r_count < MAX_C);
        w_ovf_hit   = w_hit && (r_count == MAX_C);
        w_count_nxt = r_count + CNT_W'(w_wr);
`ifdef SPRITE_OVERFLOW_EN
        w_early_full = 1'b0;
`else
        w_early_full = (w_count_nxt == MAX_C);
`endif
    end

    // Fields the scanner does not use.
    assign w_unused = ^{i_oam_data[29:28], i_oam_data[17:0], r_ovf};

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a start in any state restarts the scan and suppresses publishing.
    always_comb begin
        w_state_nxt = r_state;
        w_pub       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_SCAN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (i_start) begin
                    w_state_nxt = ST_SCAN;
                end else if (w_early_full) begin
                    w_state_nxt = ST_PUBLISH;
                    w_pub       = 1'b1;
                end else if (r_addr == LAST_ADDR) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_DRAIN: begin
                if (i_start) begin
                    w_state_nxt = ST_SCAN;
                end else begin
                    w_state_nxt = ST_PUBLISH;
                    w_pub       = 1'b1;
                end
            end
            ST_PUBLISH: begin
                if (i_start) begin
                    w_state_nxt = ST_SCAN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Address generator, evaluation pipeline and private work buffer.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_line       <= '0;
            r_addr       <= '0;
            r_eval_valid <= 1'b0;
            r_eval_idx   <= '0;
            r_count      <= '0;
            r_ovf        <= 1'b0;
            for (int k = 0; k < MAX_PER_LINE; k++) begin
                r_wb_idx[k] <= '0;
                r_wb_row[k] <= '0;
            end
        end else begin
            r_eval_idx <= r_addr;
            if (i_start) begin
                r_line       <= i_line;
                r_addr       <= '0;
                r_eval_valid <= 1'b0;
                r_count      <= '0;
                r_ovf        <= 1'b0;
                for (int k = 0; k < MAX_PER_LINE; k++) begin
                    r_wb_idx[k] <= '0;
                    r_wb_row[k] <= '0;
                end
            end else begin
                r_eval_valid <= (r_state == ST_SCAN) && !w_pub;
                if ((r_state == ST_SCAN) && (r_addr != LAST_ADDR) && !w_pub) begin
                    r_addr <= r_addr + OAM_ADDR_W'(1);
                end
                if (w_wr) begin
                    r_count <= w_count_nxt;
                end
                for (int k = 0; k < MAX_PER_LINE; k++) begin
                    if (w_wr && (r_count == CNT_W'(k))) begin
                        r_wb_idx[k] <= r_eval_idx;
                        r_wb_row[k] <= w_row;
                    end
                end
                if (w_ovf_hit) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    // Published list; merges the hit evaluated in the publishing cycle so no word is lost.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pub_idx   <= '0;
            r_pub_row   <= '0;
            r_pub_valid <= '0;
            r_pub_count <= '0;
            r_pub_ovf   <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_done <= w_pub;
            r_busy <= (w_state_nxt != ST_IDLE);
            if (w_pub) begin
                for (int k = 0; k < MAX_PER_LINE; k++) begin
                    if (CNT_W'(k) < w_count_nxt) begin
                        r_pub_valid[k] <= 1'b1;
                        if (w_wr && (r_count == CNT_W'(k))) begin
                            r_pub_idx[k*OAM_ADDR_W +: OAM_ADDR_W] <= r_eval_idx;
                            r_pub_row[k*ROW_W +: ROW_W]           <= w_row;
                        end else begin
                            r_pub_idx[k*OAM_ADDR_W +: OAM_ADDR_W] <= r_wb_idx[k];
                            r_pub_row[k*ROW_W +: ROW_W]           <= r_wb_row[k];
                        end
                    end else begin
                        r_pub_valid[k]                        <= 1'b0;
                        r_pub_idx[k*OAM_ADDR_W +: OAM_ADDR_W] <= '0;
                        r_pub_row[k*ROW_W +: ROW_W]           <= '0;
                    end
                end
                r_pub_count <= w_count_nxt;
`ifdef SPRITE_OVERFLOW_EN
                r_pub_ovf   <= r_ovf | w_ovf_hit;
`else
                r_pub_ovf   <= 1'b0;
`endif
            end
        end
    end

    assign o_oam_addr    = r_addr;
    assign o_entry_idx   = r_pub_idx;
    assign o_entry_row   = r_pub_row;
    assign o_entry_valid = r_pub_valid;
    assign o_entry_count = r_pub_count;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_overflow    = r_pub_ovf;

endmodule

// File: tb/tb_sprite_line_scanner.sv
// Self-checking bench for sprite_line_scanner: directed cases plus randomized OAM vs. a list model.
module tb_sprite_line_scanner;

    localparam int MAXN  = 32;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int RW    = 4;
    localparam int CW    = 10;
    localparam int CNTW  = 6;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [CW-1:0]        line;
    logic [AW-1:0]        oam_addr;
    logic [31:0]          oam_data = 32'd0;
    logic [MAXN*AW-1:0]   entry_idx;
    logic [MAXN*RW-1:0]   entry_row;
    logic [MAXN-1:0]      entry_valid;
    logic [CNTW-1:0]      entry_count;
    logic                 busy;
    logic                 done;
    logic                 overflow;

    logic [31:0] mem [DEPTH];
    int n_checks = 0;
    int n_fail   = 0;
    int e_idx [MAXN];
    int e_row [MAXN];
    int e_cnt, e_ovf, e_lat;

    sprite_line_scanner dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_line(line),
        .o_oam_addr(oam_addr), .i_oam_data(oam_data),
        .o_entry_idx(entry_idx), .o_entry_row(entry_row), .o_entry_valid(entry_valid),
        .o_entry_count(entry_count), .o_busy(busy), .o_done(done), .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    // OAM: synchronous RAM, one cycle read latency
    always @(posedge clk) oam_data <= mem[oam_addr];

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] spr(input bit en, input bit yf, input int ypos);
        logic [9:0]  y  = 10'(ypos);
        logic [1:0]  xf = 2'($urandom);
        logic [17:0] lo = 18'($urandom);
        return {en, yf, xf, y, lo};
    endfunction

    task automatic clear_oam();
        for (int i = 0; i < DEPTH; i++) mem[i] = spr(1'b0, 1'($urandom), int'($urandom_range(0, 1023)));
    endtask

    // Reference: walk OAM in index order and apply the hit rule with signed arithmetic.
    task automatic model(input int ln);
        e_cnt = 0;
        e_ovf = 0;
        e_lat = DEPTH + 2;
        for (int k = 0; k < MAXN; k++) begin
            e_idx[k] = 0;
            e_row[k] = 0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            int d;
            d = ln - int'(mem[i][27:18]);
            if (mem[i][31] && d >= 0 && d < 16) begin
                if (e_cnt < MAXN) begin
                    e_idx[e_cnt] = i;
                    e_row[e_cnt] = mem[i][30] ? 15 - d : d;
                    e_cnt++;
`ifndef SPRITE_OVERFLOW_EN
                    if (e_cnt == MAXN) e_lat = i + 3;
`endif
                end else begin
`ifdef SPRITE_OVERFLOW_EN
                    e_ovf = 1;
`endif
                end
            end
        end
    endtask

    task automatic check_list();
        for (int k = 0; k < MAXN; k++) begin
            chk($sformatf("idx[%0d]", k), int'(entry_idx[k*AW +: AW]), e_idx[k]);
            chk($sformatf("row[%0d]", k), int'(entry_row[k*RW +: RW]), e_row[k]);
            chk($sformatf("valid[%0d]", k), int'(entry_valid[k]), (k < e_cnt) ? 1 : 0);
        end
        chk("count", int'(entry_count), e_cnt);
        chk("overflow", int'(overflow), e_ovf);
    endtask

    task automatic pulse_start(input int ln);
        start = 1'b1;
        line  = CW'(ln);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts cycles from the start-sampling cycle until done (bounded); optional held-count probe.
    task automatic wait_done(input int hold_cnt, output int lat);
        lat = 1;
        while (!done && lat < 300) begin
            if (hold_cnt >= 0 && lat == 30) chk("held_count", int'(entry_count), hold_cnt);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic scan_check(input int ln);
        int lat;
        model(ln);
        pulse_start(ln);
        chk("busy_scan", int'(busy), 1);
        wait_done(-1, lat);
        chk("latency", lat, e_lat);
        chk("done", int'(done), 1);
        check_list();
        @(negedge clk);
        chk("done_pulse", int'(done), 0);
        chk("busy_idle", int'(busy), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, ndone, prev_cnt, ln;
        rst = 1'b1;
        start = 1'b0;
        line = '0;
        clear_oam();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(entry_count), 0);
        chk("rst_valid", int'(|entry_valid), 0);
        chk("rst_addr", int'(oam_addr), 0);
        chk("rst_ovf", int'(overflow), 0);

        // all disabled
        clear_oam();
        scan_check(100);

        // directed hits and boundaries at line 100
        clear_oam();
        mem[5]  = spr(1'b1, 1'b0, 100);
        mem[9]  = spr(1'b1, 1'b1, 90);
        mem[20] = spr(1'b1, 1'b0, 101);
        mem[21] = spr(1'b1, 1'b0, 85);
        mem[22] = spr(1'b1, 1'b0, 84);
        mem[30] = spr(1'b1, 1'b1, 1000);
        scan_check(100);
        chk("e0_idx", int'(entry_idx[5:0]), 5);
        chk("e0_row", int'(entry_row[3:0]), 0);
        chk("e1_idx", int'(entry_idx[11:6]), 9);
        chk("e1_row", int'(entry_row[7:4]), 5);
        chk("e2_idx", int'(entry_idx[17:12]), 21);
        chk("e2_row", int'(entry_row[11:8]), 15);
        chk("dir_count", int'(entry_count), 3);

        // no modular wrap-around
        clear_oam();
        mem[3] = spr(1'b1, 1'b0, 1000);
        mem[4] = spr(1'b1, 1'b1, 1020);
        scan_check(5);
        chk("wrap_count", int'(entry_count), 0);

        // 40 hits: buffer full
        clear_oam();
        for (int i = 0; i < 40; i++) mem[i] = spr(1'b1, 1'b0, 0);
        scan_check(3);
        chk("full_count", int'(entry_count), 32);
        chk("full_last_idx", int'(entry_idx[31*AW +: AW]), 31);
`ifdef SPRITE_OVERFLOW_EN
        chk("full_ovf", int'(overflow), 1);
`else
        chk("full_ovf", int'(overflow), 0);
`endif

        // restart mid-scan with line 50; previous list must hold until the single done
        prev_cnt = e_cnt;
        clear_oam();
        mem[2]  = spr(1'b1, 1'b0, 200);
        mem[7]  = spr(1'b1, 1'b0, 45);
        mem[12] = spr(1'b1, 1'b1, 50);
        pulse_start(200);
        ndone = 0;
        for (int c = 0; c < 19; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        model(50);
        pulse_start(50);
        wait_done(prev_cnt, lat);
        chk("restart_early_done", ndone, 0);
        chk("restart_latency", lat, 66);
        check_list();
        chk("restart_e0", int'(entry_idx[5:0]), 7);
        @(negedge clk);
        chk("restart_done_pulse", int'(done), 0);

        // reset mid-scan aborts, then a normal scan
        clear_oam();
        mem[0] = spr(1'b1, 1'b0, 10);
        pulse_start(10);
        repeat (9) @(negedge clk);
        chk("mid_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_count", int'(entry_count), 0);
        chk("mrst_valid", int'(|entry_valid), 0);
        chk("mrst_idx", int'(|entry_idx), 0);
        chk("mrst_addr", int'(oam_addr), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_done", int'(done), 0);
        scan_check(12);
        chk("mrst_row", int'(entry_row[3:0]), 2);

        // randomized back-to-back scans, each next start taken on the PUBLISH cycle
        for (int it = 0; it < 10; it++) begin
            int thr;
            ln  = int'($urandom_range(0, 1023));
            thr = int'($urandom_range(20, 95));
            for (int i = 0; i < DEPTH; i++) begin
                int yp;
                yp = (ln + 1024 + 4 - int'($urandom_range(0, 24))) % 1024;
                mem[i] = spr(($urandom % 100) < thr, 1'($urandom), yp);
            end
            model(ln);
            pulse_start(ln);
            wait_done(-1, lat);
            chk("rnd_latency", lat, e_lat);
            check_list();
        end
        @(negedge clk);
        chk("rnd_done_pulse", int'(done), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
